// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side handshake bundle of the direct-mapped instruction cache.
// slave is the cache's view; master is the core/memory environment's view.
interface icache_dm_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        inv;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport slave (
        input  req_valid, req_addr, inv, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_instr, mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, inv, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_instr, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with word-by-word line refill and whole-cache invalidate.
// Hit: 1-cycle latency, 1 instr/cycle; miss or invalidate drops req_ready until done.
module icache_dm #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    icache_dm_if.slave  bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, INVAL} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q;
    logic [OFF_W-1:0]   cnt_q;
    logic               inv_pend_q, inv_pend_d;
    logic [31:0]        hold_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES*LINE_WORDS];

    logic [OFF_W-1:0]   off;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [31:0]        rdata;
    logic               hit, lookup_hit, inv_eff, req_ready, accept, last_beat;

    assign off       = addr_q[2 +: OFF_W];
    assign idx       = addr_q[2+OFF_W +: IDX_W];
    assign tag       = addr_q[31 -: TAG_W];
    assign rdata     = data_q[{idx, off}];
    assign last_beat = (cnt_q == OFF_W'(LINE_WORDS - 1));

    always_comb begin
        hit        = valid_q[idx] && (tag_q[idx] == tag);
        lookup_hit = (state_q == LOOKUP) && hit;
        // A fresh inv pulse blocks acceptance in the same cycle.
        inv_eff    = inv_pend_q || bus.inv;
        req_ready  = ((state_q == IDLE) || lookup_hit) && !inv_eff;
        accept     = bus.req_valid && req_ready;
        inv_pend_d = bus.inv || (inv_pend_q && (state_q != INVAL));
        state_d    = state_q;
        case (state_q)
            IDLE: begin
                if (inv_eff)     state_d = INVAL;
                else if (accept) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (!hit)        state_d = MISS_REQ;
                else if (inv_eff) state_d = INVAL;
                else if (accept) state_d = LOOKUP;
                else             state_d = IDLE;
            end
            MISS_REQ: if (bus.mem_req_ready) state_d = REFILL;
            REFILL:   if (bus.mem_rsp_valid && last_beat) state_d = LOOKUP;
            INVAL:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            inv_pend_q <= 1'b0;
            hold_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            inv_pend_q <= inv_pend_d;
            if (accept)     addr_q <= bus.req_addr;
            if (lookup_hit) hold_q <= rdata;
            // The line stays invalid while partially written.
            if ((state_q == MISS_REQ) && bus.mem_req_ready) begin
                cnt_q        <= '0;
                valid_q[idx] <= 1'b0;
            end
            if ((state_q == REFILL) && bus.mem_rsp_valid) begin
                data_q[{idx, cnt_q}] <= bus.mem_rsp_data;
                cnt_q                <= cnt_q + 1'b1;
                if (last_beat) begin
                    valid_q[idx] <= 1'b1;
                    tag_q[idx]   <= tag;
                end
            end
            if (state_q == INVAL) valid_q <= '0;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.rsp_valid     = lookup_hit;
    assign bus.rsp_instr     = lookup_hit ? rdata : hold_q;
    assign bus.mem_req_valid = (state_q == MISS_REQ);
    assign bus.mem_req_addr  = (state_q == MISS_REQ) ? (addr_q & ~LINE_MASK) : '0;
endmodule
